blink_monitor: RTL
==================

BLINK_MONITOR -- requirements
Module: blink_monitor

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 1, expected blink rate of the monitored signal in Hz.
REQ-003 Parameter TOL_CYCLES, default 1000, allowed deviation of one half-period, in clock cycles.
REQ-004 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sig_in  input  1  monitored blink signal (e.g. LED loopback); asynchronous to clk.
REQ-007 half_period  output  26  last measured cycles between consecutive sig_in edges.
REQ-008 meas_valid  output  1  one-cycle pulse when half_period updates.
REQ-009 in_range  output  1  the last measurement was within tolerance; updated together with half_period.
REQ-010 stuck  output  1  no edge seen for TIMEOUT_CYCLES.
REQ-011 good_count  output  16  saturating count of in-range measurements.

Function
REQ-012 Constants SHALL be EXPECTED = CLK_FREQ_HZ/(2*BLINK_HZ) and TIMEOUT_CYCLES = 2*EXPECTED; both SHALL fit in 26 bits, with an elaboration-time error if they do not.
REQ-013 sig_in SHALL pass through a 2-flop synchronizer; a third flop SHALL hold the previous synchronized value; an edge is any difference between the last two flops (rising or falling).
REQ-014 FSM states: IDLE (no reference edge yet) and MEASURE.
REQ-015 IDLE: on an edge, counter <= 1 and go to MEASURE; no meas_valid pulse is produced.
REQ-016 MEASURE, non-edge cycle: counter increments by 1.
REQ-017 MEASURE, edge cycle: half_period <= counter; meas_valid <= 1 in the next cycle; counter <= 1; stay in MEASURE.
REQ-018 Edges N cycles apart on sig_in SHALL yield half_period = N exactly; the synchronizer delay is constant and cancels.
REQ-019 meas_valid SHALL rise 4 clk cycles after the first clk edge that samples the new sig_in level, and SHALL last 1 cycle.
REQ-020 in_range <= (|counter - EXPECTED| <= TOL_CYCLES), registered in the same cycle as half_period; the unsigned difference SHALL be computed without wrap.
REQ-021 good_count SHALL increment on each in-range measurement and saturate at 65535.
REQ-022 MEASURE, counter reaches TIMEOUT_CYCLES with no edge: stuck <= 1, go to IDLE, counter holds, and no measurement is produced.
REQ-023 stuck SHALL clear on the next detected edge; that edge acts as the IDLE reference edge (REQ-015).
REQ-024 If an edge and the timeout occur in the same cycle, the edge SHALL win (measurement per REQ-017, stuck stays 0).
REQ-025 Back-to-back edges on consecutive cycles SHALL give half_period = 1 with in_range per REQ-020, and pulses SHALL not be merged.

Reset
REQ-026 When rst is high: state IDLE; counter, half_period, good_count = 0; meas_valid, in_range, stuck = 0; synchronizer flops = 0.
REQ-027 rst SHALL take effect mid-measurement with no pending meas_valid after release; the first post-reset edge SHALL only arm the FSM.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding and the counter width constant (26).
REQ-029 A single sub-module, sync_edge_detect (2-flop synchronizer plus edge pulse), SHALL be instantiated; the rest SHALL be flat.

Verification (sim params CLK_FREQ_HZ=1000, BLINK_HZ=10, TOL_CYCLES=2 -> EXPECTED=50, TIMEOUT=100)
REQ-030 Toggle sig_in every 50 cycles for 6 edges -> 5 meas_valid pulses, half_period=50, in_range=1, good_count=5.
REQ-031 Toggle every 53 cycles -> half_period=53, in_range=0, good_count unchanged; every 48 cycles -> in_range=1.
REQ-032 Hold sig_in constant 100 cycles after an edge -> stuck=1 at count 100; next edge -> stuck=0, no pulse; following edge 50 later -> half_period=50.
REQ-033 Edge arriving exactly when counter=100 -> meas_valid pulse with half_period=100, stuck stays 0.
REQ-034 Assert rst for 1 cycle at counter=30 -> all outputs 0; the next edge gives no pulse; the edge 50 later gives half_period=50.
REQ-035 Force 70000 in-range measurements (shortened via force) -> good_count saturates at 65535.

Source files
------------

// File: rtl/blink_monitor_pkg.sv
// rtl/blink_monitor_pkg.sv - shared state encoding, counter width and helpers for blink_monitor
package blink_monitor_pkg;

  localparam int CNT_W = 26;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Unsigned distance that never wraps, regardless of operand order.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-flop synchronizer with registered any-edge pulse
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic edge_pulse
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability; s3 holds the previous synchronized level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      s1         <= d;
      s2         <= s1;
      s3         <= s2;
      edge_pulse <= s2 ^ s3;
    end
  end

endmodule

// File: rtl/blink_monitor.sv
// rtl/blink_monitor.sv - measures half-periods of a blink signal, flags tolerance and stuck input
module blink_monitor
  import blink_monitor_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int BLINK_HZ    = 1,
  parameter int TOL_CYCLES  = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stuck,
  output logic [15:0]      good_count
);

  localparam longint EXPECTED       = longint'(CLK_FREQ_HZ) / (longint'(2) * longint'(BLINK_HZ));
  localparam longint TIMEOUT_CYCLES = longint'(2) * EXPECTED;
  localparam longint CNT_MAX        = (longint'(1) << CNT_W) - 1;

  if (EXPECTED > CNT_MAX || TIMEOUT_CYCLES > CNT_MAX) begin : g_width_err
    $error("blink_monitor: EXPECTED/TIMEOUT_CYCLES do not fit in the counter width");
  end

  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXPECTED);
  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TOL_C = CNT_W'(TOL_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic             edge_det;
  logic             meas_pending;
  logic             hit;

  sync_edge_detect u_sync (
    .clk        (clk),
    .rst        (rst),
    .d          (sig_in),
    .edge_pulse (edge_det)
  );

  assign hit = (abs_diff(counter, EXP_C) <= TOL_C);

  // meas_valid trails the half_period update by one cycle through meas_pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      half_period  <= '0;
      meas_pending <= 1'b0;
      meas_valid   <= 1'b0;
      in_range     <= 1'b0;
      stuck        <= 1'b0;
      good_count   <= '0;
    end else begin
      meas_valid   <= meas_pending;
      meas_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (edge_det) begin
            counter <= CNT_W'(1);
            stuck   <= 1'b0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          // An edge on the timeout cycle still counts as a measurement.
          if (edge_det) begin
            half_period  <= counter;
            in_range     <= hit;
            meas_pending <= 1'b1;
            counter      <= CNT_W'(1);
            if (hit && good_count != 16'hFFFF) begin
              good_count <= good_count + 16'd1;
            end
          end else if (counter == TO_C) begin
            stuck <= 1'b1;
            state <= IDLE;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
